// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict: EX-stage branch resolution with bimodal PC-indexed predictor and statistics
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   if_valid, if_pc   IF-stage lookup request
//   if_pred_taken     combinational prediction for if_pc
//   ex_*  (inputs)    EX-stage branch: valid, is-branch, funct3, operands, pc, target, carried prediction
//   ex_taken          resolved outcome
//   ex_mispredict     resolved outcome differs from carried prediction
//   ex_redirect_pc    correct next PC (target when taken, pc+4 otherwise)
//   ex_illegal        branch encoded with funct3 2 or 3
//   clr_stats         synchronous clear of both statistics counters
//   branch_count      saturating count of legal resolved branches
//   mispredict_count  saturating count of mispredicted legal branches
module branch_resolve_predict #(
   parameter int REG_WIDTH   = 64,
   parameter int PC_WIDTH    = 64,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 if_valid,
   input  logic [PC_WIDTH-1:0]  if_pc,
   output logic                 if_pred_taken,
   input  logic                 ex_valid,
   input  logic                 ex_branch,
   input  logic [2:0]           ex_funct3,
   input  logic [REG_WIDTH-1:0] ex_rs1,
   input  logic [REG_WIDTH-1:0] ex_rs2,
   input  logic [PC_WIDTH-1:0]  ex_pc,
   input  logic [PC_WIDTH-1:0]  ex_target,
   input  logic                 ex_pred_taken,
   output logic                 ex_taken,
   output logic                 ex_mispredict,
   output logic [PC_WIDTH-1:0]  ex_redirect_pc,
   output logic                 ex_illegal,
   input  logic                 clr_stats,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);
   logic [1:0]           bht_q [BHT_ENTRIES];
   logic [1:0]           bht_d [BHT_ENTRIES];
   logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
   logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
   logic                 resolve, legal, eq, lt_s, lt_u, cond;
   logic [IDX_W-1:0]     if_idx, ex_idx;
   logic [1:0]           cur;
   logic                 unused_ok;
   assign unused_ok = ^{if_pc[1:0], if_pc[PC_WIDTH-1:IDX_W+2]};
   always_comb begin
      resolve = ex_valid & ex_branch;
      legal   = resolve & (ex_funct3[2:1] != 2'b01);
      eq      = ex_rs1 == ex_rs2;
      lt_s    = $signed(ex_rs1) < $signed(ex_rs2);
      lt_u    = ex_rs1 < ex_rs2;
      // funct3[2:1] picks the comparison, funct3[0] inverts it (bne/bge/bgeu)
      cond    = ex_funct3[2:1] == 2'b00 ? eq : ex_funct3[2:1] == 2'b10 ? lt_s : lt_u;
      ex_taken       = legal & (cond ^ ex_funct3[0]);
      ex_mispredict  = legal & (ex_taken ^ ex_pred_taken);
      ex_illegal     = resolve & ~legal;
      ex_redirect_pc = ex_taken ? ex_target : ex_pc + PC_WIDTH'(4);
      if_idx        = if_pc[IDX_W+1:2];
      ex_idx        = ex_pc[IDX_W+1:2];
      // reads the registered table, so a same-cycle update is seen only next cycle
      if_pred_taken = if_valid & bht_q[if_idx][1];
      cur   = bht_q[ex_idx];
      bht_d = bht_q;
      if (legal)
         bht_d[ex_idx] = ex_taken ? (cur == 2'b11 ? cur : cur + 2'd1)
                                  : (cur == 2'b00 ? cur : cur - 2'd1);
      branch_count_d     = clr_stats ? '0
                         : branch_count_q + CNT_WIDTH'(legal & ~&branch_count_q);
      mispredict_count_d = clr_stats ? '0
                         : mispredict_count_q + CNT_WIDTH'(ex_mispredict & ~&mispredict_count_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bht_q              <= '{default: 2'b01};
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         bht_q              <= bht_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;
endmodule
